// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: compares the newest len accepted bits
// against a loadable pattern, with a one-cycle match pulse and a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_L = (RST_LEN > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(RST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic               seq_seen_r;
    logic [CNT_W-1:0]   match_count_r;

    logic               accept_s;
    logic [MAX_LEN-1:0] hist_n_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [LEN_W-1:0]   len_load_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;

    // Next history/fill, clamped config length and the match decision
    always_comb begin
        accept_s = inp_valid & ~cfg_we;
        hist_n_s = {hist_r[MAX_LEN-2:0], inp_bit};
        if (fill_r >= MAX_LEN_L) begin
            fill_inc_s = MAX_LEN_L;
        end else begin
            fill_inc_s = fill_r + LEN_W'(1);
        end
        if (cfg_len > MAX_LEN_L) begin
            len_load_s = MAX_LEN_L;
        end else begin
            len_load_s = cfg_len;
        end
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_r)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        // Only the newest len bits take part; fill guarantees none predate the last clear
        match_s = accept_s && (len_r != {LEN_W{1'b0}}) && (fill_inc_s >= len_r)
                  && (((hist_n_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Config, history, match pulse and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r        <= {MAX_LEN{1'b0}};
            fill_r        <= {LEN_W{1'b0}};
            pat_r         <= RST_PATTERN;
            len_r         <= RST_LEN_L;
            ovl_r         <= RST_OVERLAP;
            seq_seen_r    <= 1'b0;
            match_count_r <= {CNT_W{1'b0}};
        end else begin
            if (cfg_we) begin
                pat_r      <= cfg_pattern;
                len_r      <= len_load_s;
                ovl_r      <= cfg_overlap;
                hist_r     <= {MAX_LEN{1'b0}};
                fill_r     <= {LEN_W{1'b0}};
                seq_seen_r <= 1'b0;
            end else if (accept_s) begin
                hist_r     <= hist_n_s;
                fill_r     <= (match_s && !ovl_r) ? {LEN_W{1'b0}} : fill_inc_s;
                seq_seen_r <= match_s;
            end else begin
                seq_seen_r <= 1'b0;
            end
            if (cnt_clr) begin
                match_count_r <= match_s ? CNT_W'(1) : {CNT_W{1'b0}};
            end else if (match_s && (match_count_r != CNT_MAX)) begin
                match_count_r <= match_count_r + CNT_W'(1);
            end else begin
                match_count_r <= match_count_r;
            end
        end
    end

    assign seq_seen    = seq_seen_r;
    assign match_count = match_count_r;

endmodule
